// File: rtl/hiscore_upload_server_if.sv
// Upload-path bundle: hps_io ioctl upload signals, core pause handshake and
// the second read port of the game RAM.
interface hiscore_upload_server_if #(
  parameter int AW = 10
);
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          pause_req;
  logic          pause_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_q;
  logic          timeout_flag;

  // Upload server side
  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, pause_ack, ram_q,
    output ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, timeout_flag
  );

  // hps_io / core / RAM side
  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, pause_ack, ram_q,
    input  ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, timeout_flag
  );
endinterface

// File: rtl/hiscore_upload_server.sv
// Serves HPS upload reads from a game RAM: pauses the core, then returns one
// RAM byte per ioctl_rd strobe, stalling the HPS until each byte is valid.
module hiscore_upload_server #(
  parameter int AW          = 10,
  parameter int SIZE        = 1024,
  parameter int RD_LAT      = 2,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  hiscore_upload_server_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PAUSE     = 3'd1;
  localparam logic [2:0] S_READY     = 3'd2;
  localparam logic [2:0] S_READ      = 3'd3;
  localparam logic [2:0] S_DONE_HOLD = 3'd4;

  localparam logic [24:0] SIZE_L = 25'(SIZE);
  localparam logic [15:0] ACK_TO = 16'(ACK_TIMEOUT);
  localparam logic [2:0]  LAT    = 3'(RD_LAT);

  logic [2:0]    state_q, state_d;
  logic [15:0]   cnt_q,   cnt_d;
  logic [2:0]    lat_q,   lat_d;
  logic          busy_q,  busy_d;
  logic          preq_q,  preq_d;
  logic          rd_q,    rd_d;
  logic          tmo_q,   tmo_d;
  logic [7:0]    din_q,   din_d;
  logic [AW-1:0] addr_q,  addr_d;

  // Next-state logic; a falling ioctl_upload overrides everything else
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    busy_d  = busy_q;
    preq_d  = preq_q;
    rd_d    = 1'b0;
    tmo_d   = tmo_q;
    din_d   = din_q;
    addr_d  = addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.ioctl_upload) begin
          state_d = S_PAUSE;
          preq_d  = 1'b1;
          tmo_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_PAUSE: begin
        if (bus.pause_ack) begin
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == ACK_TO) begin
            tmo_d   = 1'b1;
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        if (bus.ioctl_rd) begin
          if (bus.ioctl_addr >= SIZE_L) begin
            din_d = 8'hFF;
          end else begin
            addr_d  = bus.ioctl_addr[AW-1:0];
            rd_d    = 1'b1;
            busy_d  = 1'b1;
            lat_d   = '0;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (lat_q == LAT) begin
          din_d   = bus.ram_q;
          busy_d  = 1'b0;
          state_d = S_DONE_HOLD;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_DONE_HOLD: state_d = S_READY;
      default:     state_d = S_IDLE;
    endcase

    // Session end: drop any in-flight read; data and timeout flag are kept
    if (!bus.ioctl_upload) begin
      state_d = S_IDLE;
      preq_d  = 1'b0;
      busy_d  = 1'b0;
      rd_d    = 1'b0;
      tmo_d   = tmo_q;
      din_d   = din_q;
      addr_d  = addr_q;
    end
  end

  // State registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      preq_q  <= 1'b0;
      rd_q    <= 1'b0;
      tmo_q   <= 1'b0;
      din_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      preq_q  <= preq_d;
      rd_q    <= rd_d;
      tmo_q   <= tmo_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
    end
  end

  // Stall is combinational on the strobe so the HPS sees it in the same cycle
  assign bus.ioctl_wait   = busy_q
                          | (bus.ioctl_rd & (state_q == S_READY))
                          | ((state_q == S_PAUSE) & bus.ioctl_upload);
  assign bus.ioctl_din    = din_q;
  assign bus.pause_req    = preq_q;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_rd       = rd_q;
  assign bus.timeout_flag = tmo_q;

endmodule

// File: tb/tb_hiscore_upload_server.sv
// Randomized self-checking bench for hiscore_upload_server with a
// transaction-level expectation model and a latency-exact RAM model.
module tb_hiscore_upload_server;

  localparam int AW      = 10;
  localparam int SIZE    = 1024;
  localparam int RD_LAT  = 2;
  localparam int ACK_TO  = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  hiscore_upload_server_if #(.AW(AW)) bus ();

  hiscore_upload_server #(
    .AW(AW), .SIZE(SIZE), .RD_LAT(RD_LAT), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk_sys (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data is only meaningful exactly RD_LAT cycles after ram_rd
  logic [7:0] mem [0:SIZE-1];
  logic [7:0] pd  [0:7];
  logic       pv  [0:7];
  logic [7:0] noise;

  always @(posedge clk) begin
    pd[0] <= mem[bus.ram_addr];
    pv[0] <= (bus.ram_rd === 1'b1);
    for (int i = 1; i < 8; i++) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
  end

  always @(negedge clk) noise = 8'($urandom);

  assign bus.ram_q = (pv[RD_LAT-1] === 1'b1) ? pd[RD_LAT-1] : noise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return {11'd0, bus.ioctl_din, bus.ioctl_wait, bus.pause_req,
            bus.ram_addr, bus.ram_rd, bus.timeout_flag};
  endfunction

  // Open a session; ack is raised in PAUSE cycle d+1 unless the timeout wins
  task automatic start_session(input int d);
    int pc;
    @(negedge clk);
    bus.ioctl_upload = 1'b1;
    bus.pause_ack    = 1'b0;
    #1;
    check("preq_idle", bus.pause_req, 0);
    @(negedge clk); #1;
    check("preq_pause", bus.pause_req, 1);
    pc = 0;
    while (bus.ioctl_wait && pc < 40) begin
      if (pc == d) bus.pause_ack = 1'b1;
      pc++;
      @(negedge clk); #1;
    end
    check("pause_cycles", pc, (d + 1 < ACK_TO) ? d + 1 : ACK_TO);
    check("timeout", bus.timeout_flag, (d >= ACK_TO) ? 1 : 0);
  endtask

  task automatic end_session(input logic exp_tmo);
    @(negedge clk);
    bus.ioctl_upload = 1'b0;
    bus.pause_ack    = 1'b0;
    @(negedge clk); #1;
    check("end_preq", bus.pause_req, 0);
    check("end_wait", bus.ioctl_wait, 0);
    check("end_tmo_hold", bus.timeout_flag, exp_tmo);
  endtask

  // One read transaction; glitch adds an illegal strobe in the busy window
  task automatic do_read(input logic [24:0] a, input logic glitch);
    logic [7:0] exp_val;
    logic       in_rng;
    int nw, pulses, pos;
    in_rng  = (a < 25'(SIZE));
    exp_val = in_rng ? mem[a[AW-1:0]] : 8'hFF;
    pulses  = 0;
    pos     = -1;
    @(negedge clk);
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = a;
    #1;
    check("wait_strobe", bus.ioctl_wait, 1);
    if (bus.ram_rd) pulses++;
    nw = 1;
    @(negedge clk);
    bus.ioctl_rd   = glitch;
    bus.ioctl_addr = a ^ 25'd1;
    #1;
    while (bus.ioctl_wait && nw < 40) begin
      if (bus.ram_rd) begin pulses++; pos = nw; end
      nw++;
      @(negedge clk);
      bus.ioctl_rd = 1'b0;
      #1;
    end
    if (bus.ram_rd) pulses++;
    check("wait_len", nw, in_rng ? RD_LAT + 2 : 1);
    check("ram_rd_count", pulses, in_rng ? 1 : 0);
    if (in_rng) begin
      check("ram_rd_pos", pos, 1);
      check("ram_addr", bus.ram_addr, a[AW-1:0]);
    end
    check("din", bus.ioctl_din, exp_val);
  endtask

  task automatic abort_read(input logic [24:0] a, input logic [7:0] old_din);
    @(negedge clk);
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = a;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    #1;
    check("abort_ram_rd", bus.ram_rd, 1);
    @(negedge clk);
    bus.ioctl_upload = 1'b0;
    bus.pause_ack    = 1'b0;
    @(negedge clk); #1;
    check("abort_preq", bus.pause_req, 0);
    check("abort_wait", bus.ioctl_wait, 0);
    check("abort_din", bus.ioctl_din, old_din);
    repeat (4) @(negedge clk);
    #1;
    check("abort_din_late", bus.ioctl_din, old_din);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] a;
    int d;
    logic tmo;
    n_checks = 0;
    n_errors = 0;
    rst_n            = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.pause_ack    = 1'b0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal read, ack 3 cycles after pause_req
    mem[5] = 8'hA5;
    start_session(3);
    do_read(25'd5, 1'b0);
    // Out of range and edge addresses
    do_read(25'd1024, 1'b0);
    do_read(25'h1000005, 1'b0);
    do_read(25'd1023, 1'b0);
    // Abort mid-read keeps the last delivered byte
    do_read(25'd5, 1'b0);
    mem[7] = 8'h5A;
    abort_read(25'd7, 8'hA5);

    // Timeout with pause_ack held low
    mem[0] = 8'h3C;
    start_session(100);
    do_read(25'd0, 1'b0);
    end_session(1'b1);

    // Busy strobe ignored, then back-to-back sequential reads
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    start_session(0);
    do_read(25'd0, 1'b1);
    do_read(25'd1, 1'b0);
    do_read(25'd2, 1'b1);
    do_read(25'd3, 1'b0);
    end_session(1'b0);

    // Randomized sessions
    for (int s = 0; s < 6; s++) begin
      d   = int'($urandom_range(0, 20));
      tmo = (d >= ACK_TO);
      start_session(d);
      for (int r = 0; r < 8; r++) begin
        case ($urandom_range(0, 5))
          0, 1, 2: a = 25'($urandom_range(0, SIZE - 1));
          3:       a = 25'($urandom_range(SIZE, 32'h1FF_FFFF));
          4:       a = 25'(SIZE - 1);
          default: a = 25'(SIZE);
        endcase
        mem[$urandom_range(0, SIZE - 1)] = 8'($urandom);
        bus.pause_ack = 1'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_read(a, (a < 25'(SIZE)) ? 1'($urandom) : 1'b0);
      end
      end_session(tmo);
    end

    // Asynchronous reset in the middle of a read, upload left high
    start_session(1);
    @(negedge clk);
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = 25'd9;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outputs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_idle_preq", bus.pause_req, 0);
    @(negedge clk); #1;
    check("post_reset_preq", bus.pause_req, 1);
    check("post_reset_wait", bus.ioctl_wait, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hiscore_upload_server.md
Name: hiscore_upload_server

Overview:
- Serves HPS upload (save) requests by reading bytes out of a game-side RAM, such as hiscore or NVRAM, and returning them on ioctl_din. This is the reverse direction of the ROM download path.
- Sits between hps_io's ioctl upload signals and a second read port on the game RAM.
- Before reading, it pauses the game core via a request/acknowledge handshake so the captured image is consistent.
- Stalls the HPS with ioctl_wait until each byte is valid.

Parameters:
- AW, 10: RAM address width.
- SIZE, 1024: number of valid bytes; reads at ioctl_addr >= SIZE return 8'hFF.
- RD_LAT, 2: RAM read latency in cycles, 1..7.
- ACK_TIMEOUT, 65535: maximum cycles spent waiting for pause_ack; 16-bit counter.

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- ioctl_upload, in, 1: level; high for the whole upload session.
- ioctl_rd, in, 1: one-cycle read strobe.
- ioctl_addr, in, 25: byte address, sampled with ioctl_rd.
- ioctl_din, out, 8: read data returned to hps_io.
- ioctl_wait, out, 1: stall to HPS; high means data not yet valid.
- pause_req, out, 1: request to the core to freeze the CPU and RAM writes.
- pause_ack, in, 1: core is frozen.
- ram_addr, out, AW: RAM read address.
- ram_rd, out, 1: RAM read enable, one cycle per byte.
- ram_q, in, 8: RAM data, valid RD_LAT cycles after the ram_rd cycle.
- timeout_flag, out, 1: sticky; pause_ack never arrived in this session.

Behaviour:
- Reset (reset_n=0, async): every output is 0, including ioctl_din=8'h00. State=IDLE, counters=0.
- ioctl_wait = busy_reg | (ioctl_rd & state==READY) | (state==PAUSE & ioctl_upload). The combinational term guarantees the stall in the same cycle as the strobe.
- FSM states: IDLE, PAUSE, READY, READ, DONE_HOLD.
- IDLE:
  - pause_req=0.
  - On ioctl_upload=1: go to PAUSE, pause_req=1 from the next cycle, clear timeout_flag and the timeout counter.
- PAUSE:
  - If pause_ack=1: go to READY.
  - Else the counter increments; when it reaches ACK_TIMEOUT, set timeout_flag=1 and go to READY. Data is served anyway.
- READY, on ioctl_rd=1 in cycle N:
  - addr >= SIZE (compare the full 25 bits): ioctl_din<=8'hFF at the end of N. No ram_rd. ioctl_wait is low from N+1.
  - addr < SIZE: ram_addr<=ioctl_addr[AW-1:0], ram_rd<=1 for exactly cycle N+1, busy_reg=1, go to READ.
- READ:
  - A latency counter counts RD_LAT cycles from cycle N+1.
  - ram_q is captured into ioctl_din at the end of cycle N+1+RD_LAT.
  - busy_reg clears at that same edge, so ioctl_wait is low from N+2+RD_LAT.
  - Then go to DONE_HOLD.
- DONE_HOLD: go to READY on the next cycle. ioctl_din holds its value until the next accepted read.
- ioctl_rd outside READY (PAUSE, READ, DONE_HOLD) is a protocol violation: ignored, with no state change and no ram_rd.
- ioctl_upload falls in any state:
  - Next state is IDLE; pause_req=0, busy_reg=0 and ram_rd=0 on the next cycle.
  - A pending RAM result is discarded; ioctl_din is unchanged.
  - timeout_flag holds until the next session starts.
- pause_ack drops while in READY or READ: ignored. The session continues and pause_req stays high.
- ram_addr holds its last value between reads.
- The address uses no wrap-around: addresses above SIZE always give FF, never an aliased RAM byte.

Test Plan:
1. Normal read: RAM[5]=8'hA5, RD_LAT=2, upload rises, pause_ack 3 cycles after pause_req, ioctl_rd at N with addr 5 → ram_rd=1 and ram_addr=5 only at N+1; ioctl_wait high N..N+3; ioctl_din=8'hA5 and ioctl_wait=0 at N+4.
2. Out of range: ioctl_rd with addr 1024 (SIZE=1024) → no ram_rd; ioctl_wait high only in N; ioctl_din=8'hFF at N+1. Addr 25'h1000005 also → FF.
3. Timeout: ACK_TIMEOUT=16, pause_ack held 0 → timeout_flag=1 after 16 PAUSE cycles, ioctl_wait high throughout PAUSE. A following read of RAM[0]=8'h3C returns 8'h3C.
4. Abort: upload drops at N+2 of a read → pause_req=0, ioctl_wait=0 at N+3; ioctl_din keeps its previous value (8'hA5) while ram_q changes.
5. Busy and back-to-back: ioctl_rd pulsed at N+1 during READ → ignored, exactly one ram_rd. Sequential reads of addr 0..3 with RAM = 11,22,33,44 return those values in order.
6. Async reset: reset_n=0 mid-READ → all outputs 0 immediately, without a clock edge. After release with upload still high → IDLE→PAUSE, pause_req=1 on the next cycle.
